// File: rtl/simon_seq_player.sv
// Simon-style sequence player: builds a random color sequence one step at a time
// from a free-running LFSR and plays it back as timed lit/dark steps.
module simon_seq_player #(
    parameter int          MS     = 50000,
    parameter int          ON_MS  = 400,
    parameter int          OFF_MS = 200,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       extend,
    input  logic       play,
    input  logic       clear,
    output logic [1:0] color,
    output logic       enable,
    output logic       busy,
    output logic       done,
    output logic [4:0] length,
    output logic       full
);

    localparam logic [25:0] ON_TC  = 26'(ON_MS * MS - 1);
    localparam logic [25:0] OFF_TC = 26'(OFF_MS * MS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [25:0] timer_reg;
    logic [3:0]  idx_reg;
    logic [15:0] lfsr_reg;
    logic        lfsr_fb;
    logic        wr_en;
    logic [1:0]  seq_mem [16];

    // Taps 16,14,13,11 counted from 1.
    assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    // Only an uncontested extend in IDLE with room left writes the store.
    assign wr_en = (state_reg == IDLE) && !clear && !play && extend && !full;

    // Store is read asynchronously so the step color can be registered together
    // with the state change that lights it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            seq_mem[length[3:0]] <= lfsr_reg[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
            idx_reg   <= '0;
            lfsr_reg  <= SEED;
            length    <= '0;
            full      <= 1'b0;
            color     <= '0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
            done     <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (clear) begin
                        length <= '0;
                        full   <= 1'b0;
                    end else if (play) begin
                        if (length != 5'd0) begin
                            idx_reg   <= '0;
                            timer_reg <= '0;
                            state_reg <= ON;
                            enable    <= 1'b1;
                            busy      <= 1'b1;
                            color     <= seq_mem[0];
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (extend && !full) begin
                        length <= length + 5'd1;
                        full   <= (length == 5'd15);
                    end
                end
                ON, OFF: begin
                    if (clear) begin
                        state_reg <= IDLE;
                        timer_reg <= '0;
                        length    <= '0;
                        full      <= 1'b0;
                        enable    <= 1'b0;
                        color     <= '0;
                        busy      <= 1'b0;
                    end else if (state_reg == ON) begin
                        if (timer_reg == ON_TC) begin
                            state_reg <= OFF;
                            timer_reg <= '0;
                            enable    <= 1'b0;
                            color     <= '0;
                        end else begin
                            timer_reg <= timer_reg + 26'd1;
                        end
                    end else if (timer_reg == OFF_TC) begin
                        timer_reg <= '0;
                        if ({1'b0, idx_reg} == length - 5'd1) begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx_reg   <= idx_reg + 4'd1;
                            state_reg <= ON;
                            enable    <= 1'b1;
                            color     <= seq_mem[idx_reg + 4'd1];
                        end
                    end else begin
                        timer_reg <= timer_reg + 26'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_seq_player.sv
// Bench for simon_seq_player: expected colors are queued when steps are added and
// playback is requested, then consumed as each lit step appears on the outputs.
module tb_simon_seq_player;

    localparam int          MS      = 2;
    localparam int          ON_MS   = 3;
    localparam int          OFF_MS  = 2;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          ON_CYC  = ON_MS * MS;
    localparam int          OFF_CYC = OFF_MS * MS;

    logic       clk;
    logic       rst;
    logic       extend;
    logic       play;
    logic       clear;
    logic [1:0] color;
    logic       enable;
    logic       busy;
    logic       done;
    logic [4:0] length;
    logic       full;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  exp_seq [16];
    int          exp_len = 0;
    logic [1:0]  sb [$];

    simon_seq_player #(
        .MS(MS),
        .ON_MS(ON_MS),
        .OFF_MS(OFF_MS),
        .SEED(SEED)
    ) dut (
        .clk(clk),
        .rst(rst),
        .extend(extend),
        .play(play),
        .clear(clear),
        .color(color),
        .enable(enable),
        .busy(busy),
        .done(done),
        .length(length),
        .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, shift left.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_extend();
        if (exp_len < 16) begin
            exp_seq[exp_len] = m_lfsr[1:0];
            exp_len++;
        end
        extend = 1'b1;
        tick();
        extend = 1'b0;
        check_eq("ext_len", 32'(length), 32'(exp_len));
        check_eq("ext_full", 32'(full), 32'(exp_len == 16));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_len = 0;
        check_eq("clear_len", 32'(length), 0);
    endtask

    // Plays the stored sequence and checks step colors and lit/dark timing.
    task automatic run_play(input logic hold_ext);
        int         busy_cnt = 0;
        int         on_run   = 0;
        int         off_run  = 0;
        int         steps    = 0;
        int         c        = 0;
        logic       prev_en  = 1'b0;
        logic [1:0] cur      = 2'b00;
        for (int i = 0; i < exp_len; i++) sb.push_back(exp_seq[i]);
        play   = 1'b1;
        extend = hold_ext;
        tick();
        play = 1'b0;
        while (!done && c < 400) begin
            if (busy) busy_cnt++;
            if (enable) begin
                if (!prev_en) begin
                    if (steps > 0) check_eq("off_len", 32'(off_run), 32'(OFF_CYC));
                    cur     = (sb.size() > 0) ? sb.pop_front() : 2'bxx;
                    on_run  = 0;
                    off_run = 0;
                    steps++;
                end
                on_run++;
                check_eq("step_color", 32'(color), 32'(cur));
            end else begin
                if (prev_en) check_eq("on_len", 32'(on_run), 32'(ON_CYC));
                if (busy) off_run++;
                check_eq("dark_color", 32'(color), 0);
            end
            prev_en = enable;
            tick();
            c++;
        end
        extend = 1'b0;
        check_eq("done_seen", 32'(done), 1);
        check_eq("last_off_len", 32'(off_run), 32'(OFF_CYC));
        check_eq("steps", 32'(steps), 32'(exp_len));
        check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_len * (ON_CYC + OFF_CYC)));
        check_eq("busy_at_done", 32'(busy), 0);
        tick();
        check_eq("done_pulse_end", 32'(done), 0);
        check_eq("len_after_play", 32'(length), 32'(exp_len));
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        extend = 1'b0;
        play   = 1'b0;
        clear  = 1'b0;
        tick();
        tick();
        check_eq("rst_color", 32'(color), 0);
        check_eq("rst_enable", 32'(enable), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_length", 32'(length), 0);
        check_eq("rst_full", 32'(full), 0);
        check_eq("rst_lfsr", 32'(dut.lfsr_reg), 32'(SEED));
        rst = 1'b0;

        // Play with an empty sequence: single done pulse, nothing lights.
        play = 1'b1;
        tick();
        play = 1'b0;
        check_eq("empty_done", 32'(done), 1);
        check_eq("empty_busy", 32'(busy), 0);
        check_eq("empty_enable", 32'(enable), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("empty_done_after", 32'(done), 0);
            check_eq("empty_busy_after", 32'(busy), 0);
        end

        // Three steps, then playback.
        for (int i = 0; i < 3; i++) begin
            do_extend();
            tick();
        end
        run_play(1'b0);

        // Fill to 16; the 17th extend must change nothing.
        do_clear();
        for (int i = 0; i < 17; i++) do_extend();
        run_play(1'b0);

        // Clear on the 3rd lit cycle of the first step aborts playback.
        play = 1'b1;
        tick();
        play = 1'b0;
        tick();
        tick();
        check_eq("abort_pre_enable", 32'(enable), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        exp_len = 0;
        check_eq("abort_enable", 32'(enable), 0);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_length", 32'(length), 0);
        check_eq("abort_done", 32'(done), 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("abort_no_done", 32'(done), 0);
        end

        // Asynchronous reset between edges during the dark gap.
        do_extend();
        play = 1'b1;
        tick();
        play = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("pre_rst_busy", 32'(busy), 1);
        check_eq("pre_rst_enable", 32'(enable), 0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_length", 32'(length), 0);
        check_eq("arst_full", 32'(full), 0);
        check_eq("arst_enable", 32'(enable), 0);
        check_eq("arst_color", 32'(color), 0);
        check_eq("arst_done", 32'(done), 0);
        check_eq("arst_lfsr", 32'(dut.lfsr_reg), 32'(SEED));
        #1;
        rst = 1'b0;
        exp_len = 0;
        tick();
        for (int i = 0; i < 12; i++) begin
            check_eq("post_rst_done", 32'(done), 0);
            check_eq("post_rst_busy", 32'(busy), 0);
            tick();
        end

        // play outranks extend in IDLE; extend held through playback is ignored.
        do_extend();
        do_extend();
        run_play(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simon_seq_player.md
SIMON_SEQ_PLAYER -- requirements
Module: simon_seq_player

Interface
REQ-001 The block SHALL have parameter MS, default 50000, meaning clock cycles per millisecond.
REQ-002 The block SHALL have parameter ON_MS, default 400, meaning lit time per step in ms.
REQ-003 The block SHALL have parameter OFF_MS, default 200, meaning dark gap after each step in ms.
REQ-004 The block SHALL have parameter SEED, default 16'hACE1, meaning the LFSR reset value; it must be nonzero.
REQ-005 The block SHALL have one clock and an asynchronous active-high reset: clk  in  1  system clock, all state changes on its rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 extend  in  1  level-sampled request to append one random color.
REQ-008 play  in  1  level-sampled request to play back the stored sequence.
REQ-009 clear  in  1  level-sampled request to empty the sequence or abort playback.
REQ-010 color  out  2  step color (0 green, 1 red, 2 blue, 3 yellow), for the downstream LED control color input.
REQ-011 enable  out  1  high while a step is lit, for the downstream LED control enable input.
REQ-012 busy  out  1  high while playback is in progress.
REQ-013 done  out  1  one-cycle pulse when playback completes.
REQ-014 length  out  5  number of stored steps, 0..16.
REQ-015 full  out  1  high when length == 16.

Function
REQ-016 A 16-bit Fibonacci LFSR SHALL advance every clk cycle in every state. Taps: 16,14,13,11. Shift left, feedback into bit 0.
REQ-017 The sequence store SHALL hold 16 entries of 2 bits.
REQ-018 The FSM SHALL have three states: IDLE, ON and OFF. All outputs SHALL decode from registered state only, with no input-to-output combinational path.
REQ-019 In IDLE, requests SHALL follow priority clear > play > extend, and only the winner SHALL act.
REQ-020 IDLE with extend and length < 16: seq[length] <= lfsr[1:0] and length <= length+1, both visible the next cycle.
REQ-021 IDLE with extend and full: no effect.
REQ-022 IDLE with clear: length <= 0; store contents are don't-care.
REQ-023 IDLE with play and length > 0: step index idx <= 0, timer <= 0, state <= ON.
REQ-024 IDLE with play and length == 0: done SHALL pulse for one cycle, busy stays 0 and the state stays IDLE.
REQ-025 ON SHALL last exactly ON_MS*MS cycles with enable=1 and color=seq[idx], then go to OFF with the timer cleared.
REQ-026 OFF SHALL last exactly OFF_MS*MS cycles with enable=0. At its end: if idx == length-1, go to IDLE and pulse done for one cycle; otherwise idx <= idx+1 and go to ON.
REQ-027 busy SHALL be 1 exactly when the state is ON or OFF.
REQ-028 color SHALL be 0 whenever enable=0.
REQ-029 During ON or OFF, extend and play SHALL be ignored; they are not queued.
REQ-030 During ON or OFF, clear SHALL abort on the next edge: IDLE, length 0, enable 0, busy 0, no done pulse.
REQ-031 The timer SHALL be 26 bits and SHALL never wrap within a phase.
REQ-032 The terminal count SHALL be computed as (N*MS - 1) and compared by equality.

Reset
REQ-033 While rst=1, asynchronously: state IDLE, length 0, idx 0, timer 0, lfsr SEED, color 0, enable 0, busy 0, done 0, full 0. Store contents are don't-care.
REQ-034 Reset mid-playback SHALL take effect immediately, without waiting for a clock edge, and no done pulse SHALL follow.
REQ-035 After rst deasserts, the first sampled edge SHALL treat inputs as in IDLE.

Verification (bench parameters MS=2, ON_MS=3, OFF_MS=2, so ON = 6 cycles and OFF = 4 cycles)
REQ-036 Reset, then play=1 for 1 cycle with length 0 -> done=1 exactly one cycle; busy never rises; enable stays 0.
REQ-037 Three single-cycle extend pulses, then play -> length=3. enable pattern is 6 high / 4 low, three times. The colors equal the lfsr[1:0] values captured at each extend edge. done pulses on the cycle after the third OFF ends; busy is high for exactly 30 cycles.
REQ-038 17 extend pulses -> length=16 and full=1 after the 16th; the 17th changes nothing.
REQ-039 clear asserted at the 3rd cycle of the first ON -> enable=0, busy=0, length=0 on the next cycle; no done pulse.
REQ-040 rst pulsed between clock edges during OFF -> all outputs 0 before the next edge; lfsr returns to SEED.
REQ-041 play and extend both high in IDLE with length=2 -> playback starts and length stays 2.
